// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard/forwarding scheduler: forward-select codes,
// the "operand unused" Tuse marker and the default MDU latencies.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_E     = 2'd1;
   localparam logic [1:0] FWD_M     = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
   localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// MDU busy countdown: loaded on a mult/div issue in E, counts down to zero.
// md_busy covers the issue cycle plus the loaded number of following cycles.
module md_busy_cnt
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   input  logic md_is_div,
   output logic md_busy
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

   logic [CNT_W-1:0] cnt;

   // A new issue always reloads, even over a running count.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (md_start)
         cnt <= md_is_div ? DIV_LD : MULT_LD;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign md_busy = md_start | (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward scheduler for the 5-stage pipeline: Tuse/Tnew register hazards,
// D-stage forward selects and MDU busy holds. Option: HAZARD_STALL_CNT_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_Tuse_rs,
   input  logic [1:0] D_Tuse_rt,
   input  logic       D_is_md,
   input  logic [4:0] E_wa,
   input  logic [4:0] M_wa,
   input  logic [1:0] E_Tnew,
   input  logic [1:0] M_Tnew,
   input  logic       E_md_start,
   input  logic       E_md_is_div,
   output logic       stall,
   output logic       PC_en,
   output logic       FD_en,
   output logic       DE_clr,
   output logic [1:0] D_fwd_rs_sel,
   output logic [1:0] D_fwd_rt_sel,
   output logic       md_busy
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] md_stall_cycles
`endif
);

   logic e_hit_rs, m_hit_rs, e_hit_rt, m_hit_rt;
   logic stall_rs, stall_rt, md_stall;

   md_busy_cnt #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_cnt (
      .clk       (clk),
      .reset     (reset),
      .md_start  (E_md_start),
      .md_is_div (E_md_is_div),
      .md_busy   (md_busy)
   );

   // $0 is hardwired, so it can never match a producer.
   assign e_hit_rs = (D_rs != 5'd0) && (D_rs == E_wa);
   assign m_hit_rs = (D_rs != 5'd0) && (D_rs == M_wa);
   assign e_hit_rt = (D_rt != 5'd0) && (D_rt == E_wa);
   assign m_hit_rt = (D_rt != 5'd0) && (D_rt == M_wa);

   assign stall_rs = (e_hit_rs && (D_Tuse_rs < E_Tnew)) || (m_hit_rs && (D_Tuse_rs < M_Tnew));
   assign stall_rt = (e_hit_rt && (D_Tuse_rt < E_Tnew)) || (m_hit_rt && (D_Tuse_rt < M_Tnew));
   assign md_stall = D_is_md & md_busy;

   assign stall  = stall_rs | stall_rt | md_stall;
   assign PC_en  = ~stall;
   assign FD_en  = ~stall;
   assign DE_clr = stall;

   // E is the younger producer, so it takes priority over M.
   always_comb begin
      D_fwd_rs_sel = FWD_RF;
      if (e_hit_rs && (E_Tnew == 2'd0))
         D_fwd_rs_sel = FWD_E;
      else if (m_hit_rs && (M_Tnew == 2'd0))
         D_fwd_rs_sel = FWD_M;
   end

   always_comb begin
      D_fwd_rt_sel = FWD_RF;
      if (e_hit_rt && (E_Tnew == 2'd0))
         D_fwd_rt_sel = FWD_E;
      else if (m_hit_rt && (M_Tnew == 2'd0))
         D_fwd_rt_sel = FWD_M;
   end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles    <= '0;
         md_stall_cycles <= '0;
      end else begin
         if (stall)
            stall_cycles <= stall_cycles + 32'd1;
         if (md_stall)
            md_stall_cycles <= md_stall_cycles + 32'd1;
      end
   end
`endif

endmodule
